// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: data RAM, screen shadow with a write-post FIFO
// toward the display, and the memory-mapped keyboard register.
module hack_data_memory #(
  parameter int              RAM_WORDS  = 16384,
  parameter int              SCR_WORDS  = 8192,
  parameter logic [14:0]     KBD_ADDR   = 15'h6000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_ovf,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready
);

  localparam int RAM_AW   = $clog2(RAM_WORDS);
  localparam int SCR_BASE = 16384;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCR_WORDS];

  logic [12:0] r_fifo_addr [FIFO_DEPTH];
  logic [15:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;
  logic [15:0]      r_kbd;
  logic             r_kbd_ready;

  logic [31:0] w_addr_ext;
  logic        w_is_ram;
  logic        w_is_scr;
  logic        w_is_kbd;
  logic [12:0] w_scr_off;
  logic        w_scr_wr;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [15:0] w_rd_data;

  assign w_addr_ext = {17'b0, addressM};
  assign w_is_ram   = w_addr_ext < 32'(RAM_WORDS);
  assign w_is_scr   = (w_addr_ext >= 32'(SCR_BASE)) && (w_addr_ext < 32'(SCR_BASE + SCR_WORDS));
  assign w_is_kbd   = addressM == KBD_ADDR;
  // The screen base is 8K-aligned, so the word offset is just the low address bits.
  assign w_scr_off  = addressM[12:0];
  assign w_scr_wr   = writeM && w_is_scr;

  always_comb begin
    w_rd_data = '0;
    if (w_is_ram)      w_rd_data = r_ram[addressM[RAM_AW-1:0]];
    else if (w_is_scr) w_rd_data = r_scr[w_scr_off];
    else if (w_is_kbd) w_rd_data = r_kbd;
  end
  assign inM = w_rd_data;

  always_ff @(posedge clk) begin
    if (writeM && w_is_ram) r_ram[addressM[RAM_AW-1:0]] <= outM;
    if (w_scr_wr)           r_scr[w_scr_off] <= outM;
  end

  assign w_full    = r_count == (PTR_W+1)'(FIFO_DEPTH);
  assign scr_valid = r_count != '0;
  assign w_pop     = scr_valid && scr_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push    = w_scr_wr && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_scr_off;
      r_fifo_data[r_wr_ptr] <= outM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_scr_wr && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Head is masked while empty so stale storage never reaches the display.
  assign scr_addr = scr_valid ? r_fifo_addr[r_rd_ptr] : '0;
  assign scr_data = scr_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign scr_ovf  = r_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kbd       <= '0;
      r_kbd_ready <= 1'b1;
    end else if (kbd_valid && r_kbd_ready) begin
      r_kbd       <= kbd_code;
      r_kbd_ready <= 1'b0;
    end else begin
      r_kbd_ready <= 1'b1;
    end
  end
  assign kbd_ready = r_kbd_ready;

endmodule
